// File: rtl/fraction_accumulator4.sv
// Sums N_TERMS signed 7-bit fraction products, one per rising edge of Done_in.
// Each block's sum is presented saturated, and held under a Valid/Ack handshake.
module fraction_accumulator4 #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic       CLK,
    input  logic       Rst,
    input  logic       Clr,
    input  logic       Done_in,
    input  logic [6:0] Product,
    input  logic       Ack,
    output logic [6:0] Result,
    output logic       Valid,
    output logic       Ovf,
    output logic       Lost,
    output logic       Hold,
    output logic [2:0] Count
);

    // Handshake: Valid rises with a completed block and holds Result/Ovf frozen
    // until Ack is sampled high; the result transfers on the edge where Valid && Ack.
    typedef enum logic {ACCUM = 1'b0, FULL = 1'b1} state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(63);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(64);

    state_t                   state;
    logic                     done_d;
    logic signed [ACC_W-1:0]  acc;
    logic [2:0]               count_r;

    logic                     take;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_new;
    logic [3:0]               cnt_new;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [6:0]               sat_val;

    always_comb begin
        take     = Done_in & ~done_d;
        prod_ext = {{(ACC_W-7){Product[6]}}, Product};
        acc_new  = acc + prod_ext;
        cnt_new  = {1'b0, count_r} + 4'd1;
        sat_hi   = (acc_new > SAT_HI);
        sat_lo   = (acc_new < SAT_LO);
        sat_val  = acc_new[6:0];
        if (sat_hi)
            sat_val = 7'b0111111;
        else if (sat_lo)
            sat_val = 7'b1000000;
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state   <= ACCUM;
            done_d  <= 1'b0;
            acc     <= '0;
            count_r <= '0;
            Result  <= '0;
            Ovf     <= 1'b0;
            Lost    <= 1'b0;
        end else begin
            done_d <= Done_in;
            if (Clr) begin
                state   <= ACCUM;
                acc     <= '0;
                count_r <= '0;
                Result  <= '0;
                Ovf     <= 1'b0;
                Lost    <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (take) begin
                            if (cnt_new == 4'(N_TERMS)) begin
                                state   <= FULL;
                                Result  <= sat_val;
                                Ovf     <= sat_hi | sat_lo;
                                acc     <= '0;
                                count_r <= '0;
                            end else begin
                                acc     <= acc_new;
                                count_r <= cnt_new[2:0];
                            end
                        end
                    end
                    FULL: begin
                        if (Ack) begin
                            state <= ACCUM;
                            // A product arriving with the Ack opens the next block.
                            if (take) begin
                                acc     <= prod_ext;
                                count_r <= 3'd1;
                            end
                        end else if (take) begin
                            Lost <= 1'b1;
                        end
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

    assign Valid = (state == FULL);
    assign Hold  = Valid;
    assign Count = count_r;

endmodule

// File: tb/tb_fraction_accumulator4.sv
// Directed bench for fraction_accumulator4: hand-computed sums, saturation,
// stall/Lost, coincident Ack+take, Clr and asynchronous reset.
module tb_fraction_accumulator4;

    logic       CLK = 1'b0;
    logic       Rst;
    logic       Clr;
    logic       Done_in;
    logic [6:0] Product;
    logic       Ack;
    logic [6:0] Result;
    logic       Valid;
    logic       Ovf;
    logic       Lost;
    logic       Hold;
    logic [2:0] Count;

    int n_tests = 0;
    int n_fail  = 0;

    fraction_accumulator4 #(.N_TERMS(4), .ACC_W(10)) dut (
        .CLK     (CLK),
        .Rst     (Rst),
        .Clr     (Clr),
        .Done_in (Done_in),
        .Product (Product),
        .Ack     (Ack),
        .Result  (Result),
        .Valid   (Valid),
        .Ovf     (Ovf),
        .Lost    (Lost),
        .Hold    (Hold),
        .Count   (Count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One Done pulse held high for hi cycles, followed by one low cycle.
    task automatic pulse(input logic [6:0] prod, input int hi);
        Done_in = 1'b1;
        Product = prod;
        repeat (hi) tick();
        Done_in = 1'b0;
        tick();
    endtask

    task automatic ack_once();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Clr = 1'b0; Done_in = 1'b0; Product = '0; Ack = 1'b0;
        tick();
        check("rst_result", {1'b0, Result}, 8'h00);
        check("rst_valid",  {7'b0, Valid},  8'h00);
        check("rst_ovf",    {7'b0, Ovf},    8'h00);
        check("rst_lost",   {7'b0, Lost},   8'h00);
        check("rst_hold",   {7'b0, Hold},   8'h00);
        check("rst_count",  {5'b0, Count},  8'h00);
        Rst = 1'b0;
        tick();

        // Basic sum: 4 x +0.125 = +0.5
        pulse(7'h08, 1); check("basic_cnt1", {5'b0, Count}, 8'd1);
        pulse(7'h08, 1); check("basic_cnt2", {5'b0, Count}, 8'd2);
        pulse(7'h08, 1); check("basic_cnt3", {5'b0, Count}, 8'd3);
        check("basic_valid_early", {7'b0, Valid}, 8'h00);
        Done_in = 1'b1; Product = 7'h08;
        tick();
        check("basic_valid",  {7'b0, Valid},  8'h01);
        check("basic_hold",   {7'b0, Hold},   8'h01);
        check("basic_result", {1'b0, Result}, 8'h20);
        check("basic_ovf",    {7'b0, Ovf},    8'h00);
        check("basic_cnt0",   {5'b0, Count},  8'd0);
        Done_in = 1'b0;
        tick();
        ack_once();
        check("basic_ack_valid", {7'b0, Valid}, 8'h00);
        check("basic_ack_hold",  {7'b0, Hold},  8'h00);

        // Negative sum: 4 x -0.25 = -1.0
        repeat (4) pulse(7'h70, 1);
        check("neg_valid",  {7'b0, Valid},  8'h01);
        check("neg_result", {1'b0, Result}, 8'h40);
        check("neg_ovf",    {7'b0, Ovf},    8'h00);
        ack_once();

        // Saturation with 3-cycle Done pulses: 4 x +0.5 = +2.0 clamps
        pulse(7'h20, 3); check("sat_cnt1", {5'b0, Count}, 8'd1);
        pulse(7'h20, 3); check("sat_cnt2", {5'b0, Count}, 8'd2);
        pulse(7'h20, 3); check("sat_cnt3", {5'b0, Count}, 8'd3);
        pulse(7'h20, 3);
        check("sat_valid",  {7'b0, Valid},  8'h01);
        check("sat_result", {1'b0, Result}, 8'h3F);
        check("sat_ovf",    {7'b0, Ovf},    8'h01);

        // Stall: a 5th product without Ack is dropped
        pulse(7'h10, 1);
        check("stall_result", {1'b0, Result}, 8'h3F);
        check("stall_valid",  {7'b0, Valid},  8'h01);
        check("stall_lost",   {7'b0, Lost},   8'h01);
        ack_once();
        check("stall_ack_valid", {7'b0, Valid}, 8'h00);
        check("stall_ack_cnt",   {5'b0, Count}, 8'd0);
        check("stall_ack_lost",  {7'b0, Lost},  8'h01);

        // Clr drops Lost
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        check("clr_lost", {7'b0, Lost}, 8'h00);

        // Ack coincident with take
        repeat (4) pulse(7'h08, 1);
        check("co_valid1", {7'b0, Valid}, 8'h01);
        Ack = 1'b1; Done_in = 1'b1; Product = 7'h04;
        tick();
        Ack = 1'b0; Done_in = 1'b0;
        check("co_valid0", {7'b0, Valid}, 8'h00);
        check("co_cnt1",   {5'b0, Count}, 8'd1);
        tick();
        // Ack while accumulating has no effect
        ack_once();
        check("accum_ack_cnt",   {5'b0, Count}, 8'd1);
        check("accum_ack_valid", {7'b0, Valid}, 8'h00);
        repeat (3) pulse(7'h04, 1);
        check("co_valid",  {7'b0, Valid},  8'h01);
        check("co_result", {1'b0, Result}, 8'h10);
        check("co_lost",   {7'b0, Lost},   8'h00);
        ack_once();

        // Clr mid-block together with a take
        repeat (2) pulse(7'h08, 1);
        check("clr_pre_cnt", {5'b0, Count}, 8'd2);
        Clr = 1'b1; Done_in = 1'b1; Product = 7'h08;
        tick();
        Clr = 1'b0; Done_in = 1'b0;
        check("clr_cnt",   {5'b0, Count}, 8'd0);
        check("clr_lost2", {7'b0, Lost},  8'h00);
        tick();
        repeat (4) pulse(7'h08, 1);
        check("clr_result", {1'b0, Result}, 8'h20);
        check("clr_valid",  {7'b0, Valid},  8'h01);

        // Async reset with a pending result, Lost set and a partial block
        pulse(7'h08, 1);
        check("rst_pre_lost", {7'b0, Lost}, 8'h01);
        ack_once();
        repeat (2) pulse(7'h08, 1);
        check("rst_pre_cnt", {5'b0, Count}, 8'd2);
        #1;
        Rst = 1'b1;
        #1;
        check("arst_cnt",   {5'b0, Count},  8'd0);
        check("arst_lost",  {7'b0, Lost},   8'h00);
        check("arst_valid", {7'b0, Valid},  8'h00);
        check("arst_result",{1'b0, Result}, 8'h00);
        // Done already high at reset release counts once
        Done_in = 1'b1; Product = 7'h08;
        #1;
        Rst = 1'b0;
        tick();
        check("rel_cnt1", {5'b0, Count}, 8'd1);
        tick();
        check("rel_cnt1_hold", {5'b0, Count}, 8'd1);
        Done_in = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
